// File: rtl/gnrl_sram_initprt_if.sv
// Bus-side SRAM request/response bundle for the init/parity front end.
// Latency: none; wires only.
// Backpressure: req_ready from the slave; responses are never stalled.
interface gnrl_sram_initprt_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_be;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_prterr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_prterr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_prterr
  );
endinterface

// File: rtl/gnrl_sram_initprt.sv
// SRAM front end: init sweep of WCNT words, then pass-through with per-byte parity gen/check.
// Latency: writes go to the macro the accept cycle; read response one cycle after accept.
// Backpressure: req_ready=0 during the sweep (and reset), 1 in RUN; one request per cycle.
module gnrl_sram_initprt #(
  parameter int            AW      = 10,
  parameter int            DW      = 32,
  parameter int            PW      = DW/8,
  parameter int            WCNT    = 1024,
  parameter int            BWEN    = 1,
  parameter int            PRT     = 1,
  parameter logic [DW-1:0] INITVAL = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  reinit,
  output logic                  initdone,
  gnrl_sram_initprt_if.slave    bus,
  output logic                  prterr_stk,
  input  logic                  prterr_clr,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [DW+PW-1:0]      ram_wdata,
  output logic [DW+PW-1:0]      ram_bm,
  input  logic [DW+PW-1:0]      ram_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Counter is one bit wider than the address so WCNT == 2**AW is reachable.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(WCNT-1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            rsp_vld_q;
  logic            prterr_stk_q;
  logic            rsp_prterr_w;
  logic [PW-1:0]   be_eff;
  logic [DW+PW-1:0] bm_run;
  logic [PW-1:0]   wpar;
  logic [PW-1:0]   init_par;

  // Even parity per byte: bit i is the XOR of data byte i.
  function automatic logic [PW-1:0] byte_par(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < PW; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  // Write-side parity and bit mask for pass-through requests.
  always_comb begin
    be_eff   = '1;
    bm_run   = '0;
    wpar     = '0;
    init_par = '0;
    if (BWEN != 0) begin
      be_eff = bus.req_be;
    end
    if (PRT != 0) begin
      wpar     = byte_par(bus.req_wdata);
      init_par = byte_par(INITVAL);
    end
    for (int i = 0; i < PW; i++) begin
      bm_run[8*i +: 8] = {8{be_eff[i]}};
      bm_run[DW+i]     = be_eff[i];
    end
  end

  // Next state and macro/handshake outputs; everything held at 0 while in reset.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    initdone      = 1'b0;
    bus.req_ready = 1'b0;
    ram_ce        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    ram_bm        = '0;
    if (resetn) begin
      case (state_q)
        ST_INIT: begin
          ram_ce    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = cnt_q[AW-1:0];
          ram_wdata = {init_par, INITVAL};
          ram_bm    = '1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          initdone      = 1'b1;
          bus.req_ready = 1'b1;
          ram_ce        = bus.req_valid;
          ram_we        = bus.req_we;
          ram_addr      = bus.req_addr;
          ram_wdata     = {wpar, bus.req_wdata};
          ram_bm        = bm_run;
          // The request accepted alongside reinit has already been issued above.
          if (reinit) begin
            state_d = ST_INIT;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Read check covers every byte, independent of how the word was written.
  assign rsp_prterr_w = rsp_vld_q && (PRT != 0) &&
                        (byte_par(ram_rdata[DW-1:0]) != ram_rdata[DW+PW-1:DW]);

  assign bus.rsp_valid  = rsp_vld_q;
  assign bus.rsp_rdata  = ram_rdata[DW-1:0];
  assign bus.rsp_prterr = rsp_prterr_w;
  assign prterr_stk     = prterr_stk_q;

  // State, sweep counter, response valid and sticky error; setting beats clearing.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      rsp_vld_q    <= 1'b0;
      prterr_stk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= bus.req_valid & bus.req_ready & ~bus.req_we;
      if (rsp_prterr_w) begin
        prterr_stk_q <= 1'b1;
      end else if (prterr_clr) begin
        prterr_stk_q <= 1'b0;
      end
    end
  end

endmodule
